// File: rtl/bdense_seq_if.sv
// Handshake and weight-memory bundle for the bdense_seq binary dense sequencer.
// The master side is the sequencer; the slave side is its environment.
interface bdense_seq_if #(
  parameter int IWIDTH = 64,
  parameter int OWIDTH = 32,
  parameter int PAR    = 8,
  parameter int AW     = ($clog2(OWIDTH / PAR) < 1) ? 1 : $clog2(OWIDTH / PAR)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [IWIDTH-1:0]       vecX;
  logic                    w_en;
  logic [AW-1:0]           w_addr;
  logic [PAR*IWIDTH-1:0]   w_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [OWIDTH-1:0]       vecO;
  logic                    busy;

  modport master (
    input  in_valid, vecX, w_data, out_ready,
    output in_ready, w_en, w_addr, out_valid, vecO, busy
  );

  modport slave (
    output in_valid, vecX, w_data, out_ready,
    input  in_ready, w_en, w_addr, out_valid, vecO, busy
  );
endinterface

// File: rtl/bdense_seq.sv
// Time-multiplexed XNOR-popcount-threshold dense layer: evaluates PAR neurons per
// cycle from weight rows fetched out of a 1-cycle-latency synchronous memory.
module bdense_seq #(
  parameter int IWIDTH = 64,
  parameter int OWIDTH = 32,
  parameter int PAR    = 8,
  parameter int AW     = ($clog2(OWIDTH / PAR) < 1) ? 1 : $clog2(OWIDTH / PAR)
) (
  input  logic          clk,
  input  logic          rst,
  bdense_seq_if.master  bus
);
  localparam int G   = OWIDTH / PAR;
  localparam int KW  = $clog2(G + 1);
  localparam int PCW = $clog2(IWIDTH + 1);
  localparam logic [KW-1:0] G_K    = KW'(G);
  localparam logic [AW-1:0] LAST_C = AW'(G - 1);
  localparam logic [PCW:0]  THR    = (PCW + 1)'(IWIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic [AW-1:0]       c_q;
  logic                cap_q;
  logic                w_en_q;
  logic [AW-1:0]       w_addr_q;
  logic [IWIDTH-1:0]   xreg_q;
  logic [OWIDTH-1:0]   vecO_q;
  logic [OWIDTH-1:0]   vecO_d;
  logic [PAR-1:0]      grp_bits;

  function automatic logic [PCW-1:0] xnor_pop(input logic [IWIDTH-1:0] x,
                                              input logic [IWIDTH-1:0] w);
    logic [IWIDTH-1:0] m;
    logic [PCW-1:0]    pc;
    m  = ~(x ^ w);
    pc = '0;
    for (int i = 0; i < IWIDTH; i++) pc = pc + PCW'(m[i]);
    return pc;
  endfunction

  // A tie (pc == IWIDTH/2) maps to +1, matching sign(0) = +1.
  function automatic logic neuron_bit(input logic [PCW-1:0] pc);
    return ({pc, 1'b0} >= THR);
  endfunction

  always_comb begin
    int base;
    grp_bits = '0;
    for (int j = 0; j < PAR; j++)
      grp_bits[j] = neuron_bit(xnor_pop(xreg_q, bus.w_data[j*IWIDTH +: IWIDTH]));
    base   = int'(c_q) * PAR;
    vecO_d = vecO_q;
    if (cap_q) vecO_d[base +: PAR] = grp_bits;
  end

  // cap_q is last cycle's read strobe: the row data for that read is on w_data now.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      c_q      <= '0;
      cap_q    <= 1'b0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      vecO_q   <= '0;
    end else begin
      cap_q  <= w_en_q;
      vecO_q <= vecO_d;
      case (state_q)
        IDLE: begin
          w_en_q <= 1'b0;
          if (bus.in_valid) begin
            xreg_q   <= bus.vecX;
            w_en_q   <= 1'b1;
            w_addr_q <= '0;
            k_q      <= KW'(1);
            c_q      <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (k_q < G_K) begin
            w_en_q   <= 1'b1;
            w_addr_q <= k_q[AW-1:0];
            k_q      <= k_q + KW'(1);
          end else begin
            w_en_q <= 1'b0;
          end
          if (cap_q) begin
            if (c_q == LAST_C) state_q <= DONE;
            else               c_q     <= c_q + AW'(1);
          end
        end
        DONE: begin
          w_en_q <= 1'b0;
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.w_en      = w_en_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.vecO      = vecO_q;
endmodule

// File: tb/tb_bdense_seq.sv
// Directed and randomized bench for bdense_seq with IWIDTH=8, OWIDTH=4, PAR=2.
module tb_bdense_seq;
  localparam int IW = 8;
  localparam int OW = 4;
  localparam int P  = 2;
  localparam int G  = OW / P;
  localparam int AW = 1;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   cyc;
  int   acc_cyc;
  int   prev_acc;

  logic [P*IW-1:0] wmem [G];

  bdense_seq_if #(.IWIDTH(IW), .OWIDTH(OW), .PAR(P), .AW(AW)) bif ();

  bdense_seq #(.IWIDTH(IW), .OWIDTH(OW), .PAR(P), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous weight memory, 1-cycle latency; garbage when not read.
  always @(posedge clk) begin
    if (bif.w_en) bif.w_data <= wmem[bif.w_addr];
    else          bif.w_data <= (P*IW)'($urandom);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each neuron n uses row (n % P) of memory word (n / P); output is the sign of the
  // +/-1 dot product, i.e. agreements >= disagreements.
  function automatic logic [OW-1:0] ref_out(input logic [IW-1:0] x);
    logic [OW-1:0] o;
    logic [IW-1:0] row;
    for (int n = 0; n < OW; n++) begin
      row  = wmem[n / P][(n % P)*IW +: IW];
      o[n] = (2 * $countones(~(x ^ row)) >= IW);
    end
    return o;
  endfunction

  // Presents x, follows the run cycle by cycle, and stops in the first out_valid cycle.
  task automatic do_vec(input logic [IW-1:0] x, input logic [OW-1:0] exp, input string tag);
    int n;
    n = 0;
    while (!bif.in_ready && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, 32'(bif.in_ready), 32'd1);
    bif.vecX     = x;
    bif.in_valid = 1'b1;
    acc_cyc      = cyc;
    step();
    bif.vecX = ~x;
    for (int c = 1; c <= G; c++) begin
      chk({tag, "_w_en"},      32'(bif.w_en),      32'd1);
      chk({tag, "_w_addr"},    32'(bif.w_addr),    32'(c - 1));
      chk({tag, "_busy"},      32'(bif.busy),      32'd1);
      chk({tag, "_run_rdy"},   32'(bif.in_ready),  32'd0);
      chk({tag, "_early_ov"},  32'(bif.out_valid), 32'd0);
      step();
    end
    chk({tag, "_w_en_off"},  32'(bif.w_en),      32'd0);
    chk({tag, "_early_ov2"}, 32'(bif.out_valid), 32'd0);
    step();
    chk({tag, "_out_valid"}, 32'(bif.out_valid), 32'd1);
    chk({tag, "_vecO"},      32'(bif.vecO),      32'(exp));
  endtask

  initial begin
    logic [IW-1:0] x;
    n_assert      = 0;
    n_fail        = 0;
    cyc           = 0;
    rst           = 1'b1;
    bif.in_valid  = 1'b1;
    bif.vecX      = 8'hA5;
    bif.out_ready = 1'b1;
    for (int g = 0; g < G; g++) wmem[g] = '1;

    // Reset held with in_valid asserted
    step();
    step();
    chk("rst_in_ready",  32'(bif.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_vecO",      32'(bif.vecO),      32'd0);
    chk("rst_w_en",      32'(bif.w_en),      32'd0);
    chk("rst_busy",      32'(bif.busy),      32'd0);
    rst = 1'b0;
    bif.in_valid = 1'b0;

    // All-ones
    do_vec(8'hFF, 4'hF, "ones");
    bif.in_valid = 1'b0;
    step();
    chk("ones_idle_rdy", 32'(bif.in_ready),  32'd1);
    chk("ones_idle_ov",  32'(bif.out_valid), 32'd0);
    chk("ones_hold",     32'(bif.vecO),      32'hF);

    // Mixed weights with a popcount tie
    wmem[0] = 16'hF0FF;
    wmem[1] = 16'h070F;
    chk("mixed_ref", 32'(ref_out(8'h0F)), 32'hD);
    do_vec(8'h0F, 4'hD, "mixed");
    bif.in_valid = 1'b0;
    step();

    // Backpressure with in_valid held high
    bif.out_ready = 1'b0;
    do_vec(8'h0F, 4'hD, "bp");
    bif.vecX = 8'h00;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_vecO",     32'(bif.vecO),      32'hD);
      chk("bp_out_valid", 32'(bif.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bif.in_ready),  32'd0);
      chk("bp_w_en",     32'(bif.w_en),      32'd0);
    end
    bif.out_ready = 1'b1;
    step();
    chk("bp_rel_rdy",  32'(bif.in_ready),  32'd1);
    chk("bp_rel_ov",   32'(bif.out_valid), 32'd0);
    chk("bp_rel_busy", 32'(bif.busy),      32'd0);
    bif.in_valid = 1'b0;
    step();

    // Reset in cycle 2 of a run
    bif.vecX     = 8'h3C;
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_rdy",  32'(bif.in_ready),  32'd1);
    chk("mrst_w_en", 32'(bif.w_en),      32'd0);
    chk("mrst_vecO", 32'(bif.vecO),      32'd0);
    chk("mrst_busy", 32'(bif.busy),      32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_quiet_ov",   32'(bif.out_valid), 32'd0);
      chk("mrst_quiet_vecO", 32'(bif.vecO),      32'd0);
    end
    for (int g = 0; g < G; g++) wmem[g] = '1;
    do_vec(8'hFF, 4'hF, "post_rst");
    bif.in_valid = 1'b0;
    step();

    // Streaming random vectors
    bif.out_ready = 1'b1;
    prev_acc = -1;
    for (int v = 0; v < 10; v++) begin
      x = IW'($urandom);
      for (int g = 0; g < G; g++) wmem[g] = (P*IW)'($urandom);
      do_vec(x, ref_out(x), "stream");
      if (prev_acc >= 0) chk("stream_spacing", 32'(acc_cyc - prev_acc), 32'(G + 3));
      prev_acc = acc_cyc;
      step();
    end
    bif.in_valid = 1'b0;
    step();
    chk("final_idle", 32'(bif.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bdense_seq.md
# bdense_seq

Time-multiplexed sequencer for one binary dense layer of the BNN datapath. It accepts an IWIDTH-bit binarized input vector through a valid/ready handshake and evaluates OWIDTH neurons in OWIDTH/PAR groups. For each group it fetches PAR weight rows from an external synchronous weight memory and applies XNOR-popcount-threshold. It then presents the OWIDTH-bit output vector through a second valid/ready handshake. It replaces the fully combinational dense layer wherever area matters more than latency, and its output is bit-identical to that layer.

## Interface
- IWIDTH, 64: input vector width; also the weight row width.
- OWIDTH, 32: output vector width, i.e. the neuron count.
- PAR, 8: neurons evaluated per cycle; must divide OWIDTH. G = OWIDTH/PAR groups.
- AW, $clog2(G) (min 1): weight address width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  vecX is valid.
- in_ready  out  1  block can accept vecX.
- vecX  in  IWIDTH  binarized input vector (bit 1 = +1, bit 0 = -1).
- w_en  out  1  weight read strobe.
- w_addr  out  AW  weight group address.
- w_data  in  PAR*IWIDTH  weight rows; valid the cycle after the w_en/w_addr cycle (1-cycle read latency). Row j is w_data[j*IWIDTH +: IWIDTH].
- out_valid  out  1  vecO is valid.
- out_ready  in  1  consumer accepts vecO.
- vecO  out  OWIDTH  result vector.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register vecX, clear the issue counter and the capture counter, and go to RUN.
- RUN, issue phase:
  - While issue counter k < G: w_en=1, w_addr=k; k increments each cycle.
  - When k = G: w_en=0.
- RUN, capture phase:
  - A capture-valid flag is the w_en of the previous cycle.
  - When the flag is set, for j in 0..PAR-1: pc = popcount(~(xreg ^ row j)), pc width $clog2(IWIDTH+1).
  - Bit = 1 iff 2*pc >= IWIDTH. A tie gives 1 (sign(0) = +1).
  - Write bit j into vecO[c*PAR + j], where c is the capture counter; then c increments.
  - When c reaches G-1 and that group is written, go to DONE.
- DONE:
  - out_valid=1; vecO and the input register are held stable.
  - On out_valid&out_ready go to IDLE. out_valid drops the next cycle.
- in_ready=0 in RUN and DONE. in_valid is ignored there: no capture, no error.
- vecO keeps its last result in IDLE. It is overwritten group by group during the next RUN and is valid only while out_valid=1.
- Reset (any state, including mid-RUN or DONE):
  - state IDLE, in_ready=1, out_valid=0, w_en=0, w_addr=0, vecO=0, busy=0.
  - Any in-flight w_data is discarded.

## Timing
- Cycle 0 is the cycle whose rising edge samples in_valid&in_ready.
- Cycles 1..G: w_en=1, w_addr = cycle-1.
- Cycles 2..G+1: w_data for address cycle-2 is sampled at the end of the cycle.
- Cycle G+2: out_valid=1 (latency G+2 cycles from acceptance).
- If out_ready=1 in cycle G+2, the block is in IDLE with in_ready=1 in cycle G+3.
- Sustained throughput is one vector per G+3 cycles. There is no overlap of consecutive vectors.
- G=1 is legal: one issue cycle, one capture cycle, out_valid in cycle 3.
- Results leave the block in acceptance order.

## Test plan
Bench parameters: IWIDTH=8, OWIDTH=4, PAR=2 (G=2). The weight memory model is synchronous with 1-cycle latency.

- **Reset:** assert rst 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, vecO=0, w_en=0, busy=0.
- **All-ones:** vecX=8'hFF, every row 8'hFF -> w_addr 0,1 in cycles 1,2; out_valid first in cycle 4; vecO=4'hF.
- **Mixed/tie:** vecX=8'h0F, addr0 = 16'hF0FF, addr1 = 16'h070F -> popcounts 4,0,8,7 -> vecO=4'hD.
- **Backpressure:** repeat the mixed case with out_ready=0 for 10 cycles while in_valid=1 -> vecO stays 4'hD, out_valid=1, in_ready=0, w_en=0 throughout. Release -> IDLE next cycle.
- **Reset mid-run:** rst in cycle 2 of a run -> next cycle IDLE, w_en=0, vecO=0. A following vector 8'hFF with all-ones weights yields 4'hF with normal latency.
- **Streaming:** 10 random vectors, in_valid held high, out_ready=1 -> acceptances 5 cycles apart. Each vecO matches the reference model 2*popcount(xnor) >= 8 per neuron, in order.
